// File: rtl/fetch_predict_pipe.sv
// fetch_predict_pipe: owns the fetch PC and carries PC/prediction through IF/ID and ID/EX
// so the resolve stage can report them back to the branch target buffer.
module fetch_predict_pipe #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             memory_stall,
  input  logic             hazard_stall,
  input  logic [31:0]      icache_rdata,
  input  logic [31:0]      btb_next_pc,
  input  logic             btb_flush,
  input  logic             btb_taken,
  output logic [31:0]      icache_addr,
  output logic             icache_ren,
  output logic [31:0]      pc_1,
  output logic [31:0]      if_id_inst,
  output logic [31:0]      if_id_pc,
  output logic             if_id_valid,
  output logic [31:0]      ex_pc,
  output logic             ex_pred_taken,
  output logic             ex_valid,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [CNT_W-1:0] pred_taken_cnt
);
  localparam logic [31:0]      NOP     = 32'h0000_0013;
  localparam logic [CNT_W-1:0] CNT_ONE = 1;
  logic [31:0]      r_pc, r_if_inst, r_if_pc, r_ex_pc;
  logic             r_ren, r_if_pred, r_if_valid, r_ex_pred, r_ex_valid;
  logic [CNT_W-1:0] r_flush_cnt, r_pred_cnt;
  logic [31:0]      w_next_pc;
  assign w_next_pc = {btb_next_pc[31:2], 2'b00};
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pc        <= RESET_PC;
      r_ren       <= 1'b0;
      r_if_inst   <= NOP;
      r_if_pc     <= '0;
      r_if_pred   <= 1'b0;
      r_if_valid  <= 1'b0;
      r_ex_pc     <= '0;
      r_ex_pred   <= 1'b0;
      r_ex_valid  <= 1'b0;
      r_flush_cnt <= '0;
      r_pred_cnt  <= '0;
    end else begin
      r_ren <= 1'b1;
      if (!memory_stall) begin
        if (btb_flush) begin
          // drop the two wrong-path instructions in IF/ID and ID/EX
          r_pc       <= w_next_pc;
          r_if_valid <= 1'b0;
          r_if_inst  <= NOP;
          r_ex_valid <= 1'b0;
          r_ex_pred  <= 1'b0;
          if (!(&r_flush_cnt)) r_flush_cnt <= r_flush_cnt + CNT_ONE;
        end else if (hazard_stall) begin
          r_ex_valid <= 1'b0;
          r_ex_pred  <= 1'b0;
          r_ex_pc    <= r_if_pc;
        end else begin
          r_pc       <= w_next_pc;
          r_if_inst  <= icache_rdata;
          r_if_pc    <= r_pc;
          r_if_pred  <= btb_taken;
          r_if_valid <= 1'b1;
          r_ex_pc    <= r_if_pc;
          r_ex_pred  <= r_if_pred;
          r_ex_valid <= r_if_valid;
          if (btb_taken && !(&r_pred_cnt)) r_pred_cnt <= r_pred_cnt + CNT_ONE;
        end
      end
    end
  end
  assign icache_addr    = r_pc;
  assign pc_1           = r_pc;
  assign icache_ren     = r_ren;
  assign if_id_inst     = r_if_inst;
  assign if_id_pc       = r_if_pc;
  assign if_id_valid    = r_if_valid;
  assign ex_pc          = r_ex_pc;
  assign ex_pred_taken  = r_ex_valid & r_ex_pred;
  assign ex_valid       = r_ex_valid;
  assign flush_cnt      = r_flush_cnt;
  assign pred_taken_cnt = r_pred_cnt;
endmodule
